// File: rtl/conv_sram_reader.sv
`default_nettype none
// ============================================================================
// Module   : conv_sram_reader
// Brief    : Streams len bytes from a 1-cycle-latency SRAM read port starting
//            at base, packs them little-endian into 32-bit words and emits them
//            over a valid/ready handshake with keep/last sideband.
//            Optional macro CONV_SRAM_READER_WRAP_EN: addresses wrap from
//            DEPTH-1 to 0 and every base/len is accepted; without it an
//            out-of-range request is rejected with an err_o pulse.
// Revision : 1.0 - initial release
// ============================================================================
module conv_sram_reader #(
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 320
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  output logic                  sram_csb_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  input  logic [7:0]            sram_dout_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           out_data_o,
  output logic [3:0]            out_keep_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

`ifdef CONV_SRAM_READER_WRAP_EN
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
`else
  localparam logic [ADDR_WIDTH:0]   c_DEPTH     = (ADDR_WIDTH + 1)'(DEPTH);
`endif

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;       // address of the next read to issue
  logic [ADDR_WIDTH-1:0] r_rd_left;    // reads still to issue
  logic [ADDR_WIDTH-1:0] r_cap_left;   // bytes still to capture
  logic                  r_inflight;   // a read was issued on the last edge
  logic [31:0]           r_pk_data;
  logic [2:0]            r_pk_cnt;
  logic                  r_pk_full;    // packer holds a completed word
  logic                  r_pk_last;
  logic                  r_valid;
  logic [31:0]           r_data;
  logic [3:0]            r_keep;
  logic                  r_last;
  logic                  r_done_pulse;
  logic                  r_err_pulse;

  logic                  w_cap_last;
  logic [2:0]            w_cnt_nxt;
  logic [31:0]           w_data_nxt;
  logic                  w_word_done;
  logic                  w_last;
  logic                  w_out_free;
  logic                  w_move;
  logic [2:0]            w_pk_after;
  logic                  w_issue;
  logic [3:0]            w_keep;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  w_start_bad;
`ifndef CONV_SRAM_READER_WRAP_EN
  logic [ADDR_WIDTH:0]   w_end;
`endif

  // Packer merge, word completion, read-issue throttle and address stepping.
  // The throttle looks at the packer occupancy *after* this edge, including a
  // completed word leaving for the output register; that lets the next read
  // overlap the word hand-off and sustain one byte per cycle.
  always_comb begin
    w_cap_last  = r_inflight && (r_cap_left == ADDR_WIDTH'(1));
    w_cnt_nxt   = r_pk_cnt + {2'b00, r_inflight};
    w_data_nxt  = r_pk_data;
    if (r_inflight) begin
      w_data_nxt[{r_pk_cnt[1:0], 3'b000} +: 8] = sram_dout_i;
    end
    w_word_done = r_pk_full || (r_inflight && ((r_pk_cnt == 3'd3) || w_cap_last));
    w_last      = r_pk_full ? r_pk_last : w_cap_last;
    w_out_free  = !r_valid || out_ready_i;
    w_move      = w_word_done && w_out_free;
    w_pk_after  = w_move ? 3'd0 : w_cnt_nxt;
    w_issue     = (r_state == ST_RUN) && !rst_i && (w_pk_after < 3'd4);
    case (w_cnt_nxt)
      3'd1:    w_keep = 4'b0001;
      3'd2:    w_keep = 4'b0011;
      3'd3:    w_keep = 4'b0111;
      default: w_keep = 4'b1111;
    endcase
`ifdef CONV_SRAM_READER_WRAP_EN
    w_addr_nxt  = (r_addr == c_LAST_ADDR) ? '0 : r_addr + ADDR_WIDTH'(1);
    w_start_bad = 1'b0;
`else
    w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
    w_end       = {1'b0, base_addr_i} + {1'b0, len_i};
    w_start_bad = ({1'b0, base_addr_i} >= c_DEPTH) || (w_end > c_DEPTH);
`endif
  end

  // Control FSM: request acceptance, read issue counting and completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_rd_left    <= '0;
      r_cap_left   <= '0;
      r_inflight   <= 1'b0;
      r_done_pulse <= 1'b0;
      r_err_pulse  <= 1'b0;
    end else begin
      r_done_pulse <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_inflight   <= w_issue;
      if (r_inflight) begin
        r_cap_left <= r_cap_left - ADDR_WIDTH'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            if (w_start_bad) begin
              r_err_pulse <= 1'b1;
            end else if (len_i == '0) begin
              r_done_pulse <= 1'b1;
            end else begin
              r_state    <= ST_RUN;
              r_addr     <= base_addr_i;
              r_rd_left  <= len_i;
              r_cap_left <= len_i;
            end
          end
        end
        ST_RUN: begin
          if (w_issue) begin
            r_addr    <= w_addr_nxt;
            r_rd_left <= r_rd_left - ADDR_WIDTH'(1);
            if (r_rd_left == ADDR_WIDTH'(1)) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (r_valid && r_last && out_ready_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Byte packer: accumulates captured bytes, holds a finished word if blocked.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_move) begin
      r_pk_data <= '0;
      r_pk_cnt  <= 3'd0;
      r_pk_full <= 1'b0;
      r_pk_last <= 1'b0;
    end else begin
      r_pk_data <= w_data_nxt;
      r_pk_cnt  <= w_cnt_nxt;
      if (w_word_done) begin
        r_pk_full <= 1'b1;
        r_pk_last <= w_last;
      end
    end
  end

  // Output register: loads a finished word, otherwise holds until accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else if (w_move) begin
      r_valid <= 1'b1;
      r_data  <= w_data_nxt;
      r_keep  <= w_keep;
      r_last  <= w_last;
    end else if (out_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign sram_csb_o  = !w_issue;
  assign sram_addr_o = r_addr;
  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;
  assign out_keep_o  = r_keep;
  assign out_last_o  = r_last;
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = r_done_pulse ||
                       ((r_state == ST_DRAIN) && r_valid && r_last && out_ready_i);
  assign err_o       = r_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_conv_sram_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_sram_reader
// Brief    : Directed self-checking bench for conv_sram_reader with a
//            synchronous 1-cycle-latency SRAM model (mem[a] = a+1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_sram_reader;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] len;
  logic          csb;
  logic [AW-1:0] addr;
  logic [7:0]    dout;
  logic          valid;
  logic          ready;
  logic [31:0]   data;
  logic [3:0]    keep;
  logic          last;
  logic          busy;
  logic          done;
  logic          err;

  logic [7:0]    mem [0:511];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  logic [31:0]   q_data [$];
  logic [3:0]    q_keep [$];
  logic          q_last [$];
  int            q_hs   [$];
  int            q_rd   [$];
  int            q_done [$];
  int            q_err  [$];

  conv_sram_reader #(.ADDR_WIDTH(AW), .DEPTH(320)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .base_addr_i (base),
    .len_i       (len),
    .sram_csb_o  (csb),
    .sram_addr_o (addr),
    .sram_dout_i (dout),
    .out_valid_o (valid),
    .out_ready_i (ready),
    .out_data_o  (data),
    .out_keep_o  (keep),
    .out_last_o  (last),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous SRAM: data for a read sampled at edge k is visible after k
  always @(posedge clk) begin
    if (!csb) dout <= mem[addr];
  end

  // event log, sampled mid-cycle (what the next rising edge will see)
  always @(negedge clk) begin
    if (valid && ready) begin
      q_data.push_back(data);
      q_keep.push_back(keep);
      q_last.push_back(last);
      q_hs.push_back(cyc);
    end
    if (!csb) q_rd.push_back(int'(addr));
    if (done) q_done.push_back(cyc);
    if (err)  q_err.push_back(cyc);
  end

  function automatic logic [31:0] d_at(input int i);
    if (i < q_data.size()) return q_data[i];
    return 32'hDEADBEEF;
  endfunction
  function automatic logic [3:0] k_at(input int i);
    if (i < q_keep.size()) return q_keep[i];
    return 4'hX;
  endfunction
  function automatic logic l_at(input int i);
    if (i < q_last.size()) return q_last[i];
    return 1'bX;
  endfunction
  function automatic int h_at(input int i);
    if (i < q_hs.size()) return q_hs[i];
    return -1;
  endfunction
  function automatic int r_at(input int i);
    if (i < q_rd.size()) return q_rd[i];
    return -1;
  endfunction

  task automatic clear_logs();
    @(posedge clk); #1;
    q_data.delete(); q_keep.delete(); q_last.delete(); q_hs.delete();
    q_rd.delete(); q_done.delete(); q_err.delete();
  endtask

  task automatic do_start(input int b, input int l, output int s);
    base  = AW'(b);
    len   = AW'(l);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_idle(input int max, output bit to);
    to = 1'b1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
    repeat (2) begin @(negedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b1; base = '0; len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({csb, addr} !== {1'b1, 9'd0}) begin
      errors++; $display("FAIL reset_sram: csb=%b addr=%0d expected csb=1 addr=0", csb, addr);
    end
    checks++;
    if ({valid, data, keep, last} !== 38'd0) begin
      errors++; $display("FAIL reset_out: valid=%b data=%h keep=%h last=%b expected all 0", valid, data, keep, last);
    end
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("FAIL reset_status: busy=%b done=%b err=%b expected 000", busy, done, err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int s; bit to;
    clear_logs();
    ready = 1'b1;
    do_start(0, 8, s);
    wait_idle(60, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout: busy=%b expected 0", busy); end
    checks++;
    if (q_data.size() != 2) begin errors++; $display("FAIL basic_count: got %0d words expected 2", q_data.size()); end
    checks++;
    if ({d_at(0), k_at(0), l_at(0)} !== {32'h04030201, 4'hF, 1'b0}) begin
      errors++; $display("FAIL basic_w0: got %h/%h/%b expected 04030201/f/0", d_at(0), k_at(0), l_at(0));
    end
    checks++;
    if ({d_at(1), k_at(1), l_at(1)} !== {32'h08070605, 4'hF, 1'b1}) begin
      errors++; $display("FAIL basic_w1: got %h/%h/%b expected 08070605/f/1", d_at(1), k_at(1), l_at(1));
    end
    checks++;
    if (h_at(0) != s + 5) begin errors++; $display("FAIL basic_latency: first word at %0d expected %0d", h_at(0), s + 5); end
    checks++;
    if (h_at(1) != s + 9) begin errors++; $display("FAIL basic_throughput: second word at %0d expected %0d", h_at(1), s + 9); end
    checks++;
    if (q_done.size() != 1 || q_done[0] != s + 9) begin
      errors++; $display("FAIL basic_done: %0d pulses, first at %0d expected 1 at %0d", q_done.size(), (q_done.size() > 0) ? q_done[0] : -1, s + 9);
    end
    checks++;
    if (q_rd.size() != 8) begin errors++; $display("FAIL basic_reads: got %0d expected 8", q_rd.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r_at(i) != i) begin errors++; $display("FAIL basic_addr%0d: got %0d expected %0d", i, r_at(i), i); end
    end
  endtask

  task automatic test_partial();
    int s; bit to;
    clear_logs();
    do_start(10, 6, s);
    wait_idle(60, to);
    checks++;
    if (to || q_data.size() != 2) begin errors++; $display("FAIL partial_count: got %0d words timeout=%b expected 2", q_data.size(), to); end
    checks++;
    if ({d_at(0), k_at(0), l_at(0)} !== {32'h0E0D0C0B, 4'hF, 1'b0}) begin
      errors++; $display("FAIL partial_w0: got %h/%h/%b expected 0e0d0c0b/f/0", d_at(0), k_at(0), l_at(0));
    end
    checks++;
    if ({d_at(1), k_at(1), l_at(1)} !== {32'h0000100F, 4'h3, 1'b1}) begin
      errors++; $display("FAIL partial_w1: got %h/%h/%b expected 0000100f/3/1", d_at(1), k_at(1), l_at(1));
    end
  endtask

  task automatic test_keep();
    int s; bit to;
    clear_logs();
    do_start(0, 3, s);
    wait_idle(60, to);
    checks++;
    if (to || q_data.size() != 1 || {d_at(0), k_at(0), l_at(0)} !== {32'h00030201, 4'h7, 1'b1}) begin
      errors++; $display("FAIL keep3: got %0d words %h/%h/%b expected 1 word 00030201/7/1", q_data.size(), d_at(0), k_at(0), l_at(0));
    end
    clear_logs();
    do_start(20, 1, s);
    wait_idle(60, to);
    checks++;
    if (to || q_data.size() != 1 || {d_at(0), k_at(0), l_at(0)} !== {32'h00000015, 4'h1, 1'b1}) begin
      errors++; $display("FAIL keep1: got %0d words %h/%h/%b expected 1 word 00000015/1/1", q_data.size(), d_at(0), k_at(0), l_at(0));
    end
    checks++;
    if (q_done.size() != 1) begin errors++; $display("FAIL keep1_done: got %0d pulses expected 1", q_done.size()); end
  endtask

  task automatic test_stall();
    int s; bit to; bit seen;
    logic [36:0] held_w;
    clear_logs();
    ready = 1'b1;
    seen = 1'b0;
    held_w = '0;
    do_start(32, 12, s);
    repeat (3) begin @(posedge clk); #1; end
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (valid) begin
        if (!seen) begin
          held_w = {data, keep, last};
          seen = 1'b1;
        end else begin
          checks++;
          if ({data, keep, last} !== held_w) begin
            errors++; $display("FAIL stall_stable: got %h/%h/%b expected %h", data, keep, last, held_w);
          end
        end
      end
      if (i != 9) begin @(posedge clk); #1; end
    end
    checks++;
    if (held_w !== {32'h24232221, 4'hF, 1'b0} || !valid) begin
      errors++; $display("FAIL stall_word: got %h valid=%b expected 24232221/f/0 valid=1", held_w, valid);
    end
    checks++;
    if (csb !== 1'b1) begin errors++; $display("FAIL stall_csb: got %b expected 1", csb); end
    checks++;
    if (q_rd.size() != 8) begin errors++; $display("FAIL stall_reads: got %0d expected 8", q_rd.size()); end
    @(posedge clk); #1;
    ready = 1'b1;
    wait_idle(80, to);
    checks++;
    if (to || q_data.size() != 3) begin errors++; $display("FAIL stall_count: got %0d words timeout=%b expected 3", q_data.size(), to); end
    checks++;
    if ({d_at(0), k_at(0), l_at(0)} !== {32'h24232221, 4'hF, 1'b0}) begin
      errors++; $display("FAIL stall_w0: got %h/%h/%b expected 24232221/f/0", d_at(0), k_at(0), l_at(0));
    end
    checks++;
    if ({d_at(1), k_at(1), l_at(1)} !== {32'h28272625, 4'hF, 1'b0}) begin
      errors++; $display("FAIL stall_w1: got %h/%h/%b expected 28272625/f/0", d_at(1), k_at(1), l_at(1));
    end
    checks++;
    if ({d_at(2), k_at(2), l_at(2)} !== {32'h2C2B2A29, 4'hF, 1'b1}) begin
      errors++; $display("FAIL stall_w2: got %h/%h/%b expected 2c2b2a29/f/1", d_at(2), k_at(2), l_at(2));
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (r_at(i) != 32 + i) begin errors++; $display("FAIL stall_addr%0d: got %0d expected %0d", i, r_at(i), 32 + i); end
    end
    checks++;
    if (q_done.size() != 1) begin errors++; $display("FAIL stall_done: got %0d pulses expected 1", q_done.size()); end
  endtask

  task automatic test_range();
    int s; bit to;
    clear_logs();
    do_start(318, 4, s);
`ifdef CONV_SRAM_READER_WRAP_EN
    wait_idle(60, to);
    checks++;
    if (to || q_rd.size() != 4 || r_at(0) != 318 || r_at(1) != 319 || r_at(2) != 0 || r_at(3) != 1) begin
      errors++; $display("FAIL wrap_addr: got %0d reads %0d,%0d,%0d,%0d expected 318,319,0,1", q_rd.size(), r_at(0), r_at(1), r_at(2), r_at(3));
    end
    checks++;
    if ({d_at(0), k_at(0), l_at(0)} !== {32'h0201403F, 4'hF, 1'b1}) begin
      errors++; $display("FAIL wrap_word: got %h/%h/%b expected 0201403f/f/1", d_at(0), k_at(0), l_at(0));
    end
`else
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL range_busy%0d: got %b expected 0", i, busy); end
    end
    checks++;
    if (q_err.size() != 1 || q_err[0] != s) begin
      errors++; $display("FAIL range_err: %0d pulses, first at %0d expected 1 at %0d", q_err.size(), (q_err.size() > 0) ? q_err[0] : -1, s);
    end
    checks++;
    if (q_rd.size() != 0 || q_data.size() != 0 || q_done.size() != 0) begin
      errors++; $display("FAIL range_quiet: reads=%0d words=%0d done=%0d expected 0", q_rd.size(), q_data.size(), q_done.size());
    end
    clear_logs();
    do_start(330, 1, s);
    repeat (3) begin @(negedge clk); #1; end
    checks++;
    if (q_err.size() != 1 || q_rd.size() != 0) begin
      errors++; $display("FAIL range_base: err=%0d reads=%0d expected err=1 reads=0", q_err.size(), q_rd.size());
    end
`endif
    wait_idle(10, to);
  endtask

  task automatic test_reset_mid();
    int s; bit to;
    clear_logs();
    do_start(0, 16, s);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({csb, addr, valid, data, keep, last, busy, done, err} !== {1'b1, 9'd0, 38'd0, 3'b000}) begin
      errors++; $display("FAIL midrst_out: csb=%b addr=%0d valid=%b data=%h keep=%h last=%b busy=%b done=%b err=%b expected reset values",
                         csb, addr, valid, data, keep, last, busy, done, err);
    end
    repeat (6) begin @(negedge clk); #1; end
    checks++;
    if (q_done.size() != 0 || q_data.size() != 0) begin
      errors++; $display("FAIL midrst_quiet: done=%0d words=%0d expected 0", q_done.size(), q_data.size());
    end
    clear_logs();
    do_start(0, 4, s);
    wait_idle(60, to);
    checks++;
    if (to || q_data.size() != 1 || {d_at(0), k_at(0), l_at(0)} !== {32'h04030201, 4'hF, 1'b1}) begin
      errors++; $display("FAIL midrst_restart: got %0d words %h/%h/%b expected 1 word 04030201/f/1", q_data.size(), d_at(0), k_at(0), l_at(0));
    end
    checks++;
    if (q_done.size() != 1) begin errors++; $display("FAIL midrst_done: got %0d pulses expected 1", q_done.size()); end
  endtask

  task automatic test_zero_len();
    int s;
    clear_logs();
    do_start(5, 0, s);
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy); end
    repeat (4) begin @(negedge clk); #1; end
    checks++;
    if (q_done.size() != 1 || q_done[0] != s) begin
      errors++; $display("FAIL zero_done: %0d pulses, first at %0d expected 1 at %0d", q_done.size(), (q_done.size() > 0) ? q_done[0] : -1, s);
    end
    checks++;
    if (q_rd.size() != 0 || q_data.size() != 0) begin
      errors++; $display("FAIL zero_quiet: reads=%0d words=%0d expected 0", q_rd.size(), q_data.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'((i + 1) & 255);
    test_reset();
    test_basic();
    test_partial();
    test_keep();
    test_stall();
    test_range();
    test_reset_mid();
    test_zero_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/conv_sram_reader.md
CONV_SRAM_READER -- requirements
Module: conv_sram_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, SRAM address width.
REQ-002 Parameter DEPTH, default 320, number of valid SRAM byte locations.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 start_i  in  1  one-cycle request; sampled only in IDLE.
REQ-006 base_addr_i  in  ADDR_WIDTH  first byte address, captured with start_i.
REQ-007 len_i  in  ADDR_WIDTH  byte count, 0..DEPTH, captured with start_i.
REQ-008 sram_csb_o  out  1  active-low read select to the SRAM read port.
REQ-009 sram_addr_o  out  ADDR_WIDTH  read address to the SRAM read port.
REQ-010 sram_dout_i  in  8  SRAM read data.
REQ-011 out_valid_o / out_ready_i  out/in  1  output word handshake.
REQ-012 out_data_o  out  32  packed word; byte 0 in bits [7:0].
REQ-013 out_keep_o  out  4  byte-valid mask; out_last_o  out  1  final word of the transfer.
REQ-014 busy_o  out  1  high outside IDLE; done_o  out  1  one-cycle completion pulse; err_o  out  1  one-cycle error pulse.

Function
REQ-015 States IDLE, RUN, DRAIN. IDLE->RUN on start_i with len_i>0. RUN->DRAIN after the last read is issued. DRAIN->IDLE on the handshake of the out_last_o word, with done_o high in that same cycle.
REQ-016 start_i with len_i=0 remains in IDLE and pulses done_o in the next cycle.
REQ-017 A read issued at edge k (sram_csb_o=0) returns data that is captured from sram_dout_i at edge k+1; fixed 1-cycle latency.
REQ-018 Reads are issued with sequential addresses, one per cycle, only while packer_count + inflight < 4; otherwise sram_csb_o=1.
REQ-019 The packer places byte n of the transfer in lane n mod 4.
REQ-020 A completed word (4 bytes, or the final partial word) moves to the output register on its completing edge if that register is empty or handshaking; otherwise the packer holds it.
REQ-021 out_data_o, out_keep_o and out_last_o hold stable while out_valid_o=1 and out_ready_i=0.
REQ-022 Unused lanes of a partial final word read zero; out_keep_o is 4'b0001, 4'b0011 or 4'b0111.
REQ-023 With out_ready_i held high, sustained throughput is 1 byte/cycle after a first-word latency of 5 cycles from start_i.
REQ-024 sram_csb_o=1 whenever the block is not issuing a read, including every IDLE and DRAIN cycle.

Reset
REQ-025 On rst_i: state=IDLE; sram_csb_o=1; sram_addr_o=0; out_valid_o=0; out_data_o=0; out_keep_o=0; out_last_o=0; busy_o=0; done_o=0; err_o=0; packer and inflight count cleared.
REQ-026 Reset mid-transfer aborts the transfer; in-flight read data is discarded and no done_o is produced.

Configuration
REQ-027 Macro CONV_SRAM_READER_WRAP_EN.
- Defined: the address after DEPTH-1 is 0, and any base/len is legal.
- Undefined: start_i with base_addr_i+len_i > DEPTH, or base_addr_i >= DEPTH, is rejected; the block stays in IDLE, pulses err_o in the next cycle, and issues no read.

Verification
REQ-028 base=0, len=8, ready=1, SRAM bytes 01..08 -> words 0x04030201 then 0x08070605 (keep=F, last on second), done_o on last handshake.
REQ-029 base=10, len=6 -> words 0x(b13 b12 b11 b10), then 0x0000(b15 b14) with keep=3, last=1.
REQ-030 len=12, out_ready_i low for 10 cycles mid-stream -> no lost or duplicated bytes; outputs stable during stall; sram_csb_o=1 once packer+inflight=4.
REQ-031 base=318, len=4 -> with macro: addresses 318,319,0,1; without macro: err_o pulse, no read, busy_o stays 0.
REQ-032 rst_i asserted 3 cycles into len=16 -> next cycle all outputs at reset values; a new start (base=0, len=4) then completes normally.
REQ-033 len=0 -> no read, no out_valid_o, done_o one cycle after start_i.
